fpu_norm_arbiter: RTL

Shares one normalize datapath between the two FPU producers: requester 0 is add/sub and requester 1 is mul. Each requester presents an unnormalized result (exponent, carry/overflow flag, 28-bit mantissa). The block arbitrates round-robin, normalizes the winner's operands combinationally and registers the result into a one-entry output stage with a valid/ready handshake. It also keeps a saturating overflow-event counter for debug.

---
 rtl/fpu_norm_pkg.sv | 36 +++
 rtl/norm_rr_arbiter.sv | 53 +++++
 rtl/fpu_norm_arbiter.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/fpu_norm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fpu_norm_pkg
// Description : Shared constants and record types for the FPU normalize
//               arbiter (requester 0 = add/sub, requester 1 = mul).
// Revision    : 1.0 - initial release
// ============================================================================
package fpu_norm_pkg;

   localparam int unsigned EXP_W  = 8;
   localparam int unsigned MANT_W = 28;
   localparam int unsigned TAG_W  = 4;
   localparam int unsigned CNT_W  = 16;
   localparam int unsigned N_REQ  = 2;

   localparam logic [EXP_W-1:0] EXP_MAX = 8'd255;

   // One unnormalized operand set as presented by a producer
   typedef struct packed {
      logic [EXP_W-1:0]  exp;
      logic              c_alu;
      logic [MANT_W-1:0] mant;
      logic [TAG_W-1:0]  tag;
   } norm_req_t;

   // One normalized result as held in the output stage
   typedef struct packed {
      logic              src;
      logic [TAG_W-1:0]  tag;
      logic [EXP_W-1:0]  exp;
      logic [MANT_W-1:0] mant;
      logic              overflow;
   } norm_res_t;

endpackage : fpu_norm_pkg
`default_nettype wire

// File: rtl/norm_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : norm_rr_arbiter
// Description : Two-way round-robin arbiter. Owns the priority pointer, which
//               flips to the other requester only after a real transfer.
// Revision    : 1.0 - initial release
// ============================================================================
module norm_rr_arbiter
   import fpu_norm_pkg::*;
(
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [N_REQ-1:0] valid_i,
   input  logic             can_load_i,
   input  logic             flush_i,
   output logic             grant_o,
   output logic [N_REQ-1:0] ready_o,
   output logic             xfer_o
);

   logic ptr_q;
   logic ptr_d;

   // Grant: a lone requester wins outright, a tie goes to the pointer
   always_comb begin
      grant_o = ptr_q;
      ptr_d   = ptr_q;
      ready_o = '0;
      case (valid_i)
         2'b01:   grant_o = 1'b0;
         2'b10:   grant_o = 1'b1;
         default: grant_o = ptr_q;
      endcase
      if (can_load_i && !flush_i) begin
         ready_o[grant_o] = 1'b1;
      end
      xfer_o = |(valid_i & ready_o);
      if (xfer_o) begin
         ptr_d = ~grant_o;
      end
   end

   // Pointer register; holds while nothing transfers so a stalled loser keeps priority
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ptr_q <= 1'b0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule : norm_rr_arbiter
`default_nettype wire

// File: rtl/fpu_norm_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fpu_norm_arbiter
// Description : Shares one normalize datapath (leading-zero count, left shift,
//               exponent subtract) between add/sub and mul producers, with a
//               one-entry valid/ready output stage and a saturating overflow
//               event counter.
// Revision    : 1.0 - initial release
// ============================================================================
module fpu_norm_arbiter #(
   parameter int unsigned EXP_W  = 8,
   parameter int unsigned MANT_W = 28,
   parameter int unsigned TAG_W  = 4,
   parameter int unsigned CNT_W  = 16
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic                i_flush,
   input  logic [1:0]          i_req_valid,
   output logic [1:0]          o_req_ready,
   input  logic [2*EXP_W-1:0]  i_req_exp,
   input  logic [1:0]          i_req_c_alu,
   input  logic [2*MANT_W-1:0] i_req_mant,
   input  logic [2*TAG_W-1:0]  i_req_tag,
   output logic                o_valid,
   input  logic                i_ready,
   output logic                o_src,
   output logic [TAG_W-1:0]    o_tag,
   output logic [EXP_W-1:0]    o_exp,
   output logic [MANT_W-1:0]   o_mant,
   output logic                o_overflow,
   output logic [CNT_W-1:0]    o_ovf_count
);
   import fpu_norm_pkg::N_REQ;

   localparam int unsigned LZ_W = $clog2(MANT_W + 1);

   logic              w_can_load;
   logic              w_grant;
   logic [N_REQ-1:0]  w_ready;
   logic              w_xfer;

   logic [EXP_W-1:0]  w_exp_in;
   logic              w_c_in;
   logic [MANT_W-1:0] w_mant_in;
   logic [TAG_W-1:0]  w_tag_in;
   logic [LZ_W-1:0]   w_lz;
   logic [EXP_W-1:0]  w_exp_n;
   logic [MANT_W-1:0] w_mant_n;
   logic              w_ovf_n;

   logic              valid_q;
   logic              src_q;
   logic [TAG_W-1:0]  tag_q;
   logic [EXP_W-1:0]  exp_q;
   logic [MANT_W-1:0] mant_q;
   logic              ovf_q;
   logic [CNT_W-1:0]  cnt_q;

   assign w_can_load  = !valid_q || i_ready;
   assign o_req_ready = w_ready;

   norm_rr_arbiter u_arb (
      .clk_i      (i_clk),
      .rst_ni     (i_rst_n),
      .valid_i    (i_req_valid),
      .can_load_i (w_can_load),
      .flush_i    (i_flush),
      .grant_o    (w_grant),
      .ready_o    (w_ready),
      .xfer_o     (w_xfer)
   );

   // Route the winner's operands into the single shared normalizer
   always_comb begin
      w_exp_in  = w_grant ? i_req_exp[EXP_W +: EXP_W]    : i_req_exp[0 +: EXP_W];
      w_c_in    = w_grant ? i_req_c_alu[1]               : i_req_c_alu[0];
      w_mant_in = w_grant ? i_req_mant[MANT_W +: MANT_W] : i_req_mant[0 +: MANT_W];
      w_tag_in  = w_grant ? i_req_tag[TAG_W +: TAG_W]    : i_req_tag[0 +: TAG_W];
   end

   // Normalize: carry forces the saturated exponent, otherwise shift out leading zeros
   always_comb begin
      w_lz = LZ_W'(MANT_W);
      for (int i = 0; i < MANT_W; i++) begin
         if (w_mant_in[i]) begin
            w_lz = LZ_W'(MANT_W - 1 - i);
         end
      end
      if (w_c_in) begin
         w_exp_n  = '1;
         w_mant_n = w_mant_in;
         w_ovf_n  = 1'b1;
      end else begin
         w_exp_n  = w_exp_in - EXP_W'(w_lz);
         w_mant_n = w_mant_in << w_lz;
         w_ovf_n  = &w_exp_n;
      end
   end

   // Output stage: load on transfer, drain on handshake, flush drops the entry
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         valid_q <= 1'b0;
         src_q   <= 1'b0;
         tag_q   <= '0;
         exp_q   <= '0;
         mant_q  <= '0;
         ovf_q   <= 1'b0;
      end else if (i_flush) begin
         valid_q <= 1'b0;
      end else if (w_xfer) begin
         valid_q <= 1'b1;
         src_q   <= w_grant;
         tag_q   <= w_tag_in;
         exp_q   <= w_exp_n;
         mant_q  <= w_mant_n;
         ovf_q   <= w_ovf_n;
      end else if (valid_q && i_ready) begin
         valid_q <= 1'b0;
      end
   end

   // Count overflowed results as they leave; stick at all ones
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         cnt_q <= '0;
      end else if (valid_q && i_ready && ovf_q && !(&cnt_q)) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign o_valid     = valid_q;
   assign o_src       = src_q;
   assign o_tag       = tag_q;
   assign o_exp       = exp_q;
   assign o_mant      = mant_q;
   assign o_overflow  = ovf_q;
   assign o_ovf_count = cnt_q;

endmodule : fpu_norm_arbiter
`default_nettype wire
